// File: rtl/core_test_ctrl.sv
// Purpose: loads a program into a core's instruction memory, runs the core until it
//          parks in a self-branch or hits a cycle limit, then checks selected registers.
// Latency: one program beat per cycle in LOAD, one register check per cycle in CHECK.
// Backpressure: prog_ready is high only in LOAD, so the program stream stalls at any other time.
// Ports: clk/reset (sync, active-high); start; prog_* word stream; imem_* write port;
//        core_reset and pc to/from the core; exp_idx/exp_val expected registers;
//        rf_raddr/rf_rdata debug read; busy/done/pass/timeout/overflow/fail_idx/cycle_count status.
module core_test_ctrl #(
    parameter int XLEN           = 32,
    parameter int IMEM_DEPTH     = 64,
    parameter int NUM_CHECKS     = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int FW = $clog2(NUM_CHECKS) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    prog_valid,
    output logic                    prog_ready,
    input  logic [XLEN-1:0]         prog_data,
    input  logic                    prog_last,
    output logic                    imem_we,
    output logic [AW-1:0]           imem_addr,
    output logic [XLEN-1:0]         imem_wdata,
    output logic                    core_reset,
    input  logic [XLEN-1:0]         pc,
    input  logic [NUM_CHECKS*5-1:0] exp_idx,
    input  logic [NUM_CHECKS*XLEN-1:0] exp_val,
    output logic [4:0]              rf_raddr,
    input  logic [XLEN-1:0]         rf_rdata,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic                    timeout,
    output logic                    overflow,
    output logic [FW-1:0]           fail_idx,
    output logic [31:0]             cycle_count
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CHECK, DONE} state_t;

    state_t state, state_nxt;

    logic [AW-1:0]              waddr;
    logic [NUM_CHECKS*5-1:0]    exp_idx_q;
    logic [NUM_CHECKS*XLEN-1:0] exp_val_q;
    logic [XLEN-1:0]            pc_prev;
    logic [FW-1:0]              chk_k;

    logic            beat;
    logic            addr_full;
    logic            load_end;
    logic            halt;
    logic            tmo;
    logic [4:0]      chk_idx;
    logic [XLEN-1:0] chk_val;
    logic            chk_ok;
    logic            chk_last;

    // prog_ready is 1 throughout LOAD, so every valid beat in LOAD is accepted.
    assign beat      = (state == LOAD) && prog_valid;
    assign addr_full = (waddr == AW'(IMEM_DEPTH - 1));
    // The last memory word always ends the load, whether or not the stream says so.
    assign load_end  = beat && (prog_last || addr_full);
    // The first RUN cycle has no valid previous PC, hence the cycle_count guard.
    assign halt      = (cycle_count >= 32'd2) && (pc == pc_prev);
    assign tmo       = (cycle_count >= 32'(TIMEOUT_CYCLES));

    always_comb begin
        chk_idx = '0;
        chk_val = '0;
        for (int k = 0; k < NUM_CHECKS; k++) begin
            if (chk_k == FW'(k)) begin
                chk_idx = exp_idx_q[k*5 +: 5];
                chk_val = exp_val_q[k*XLEN +: XLEN];
            end
        end
    end

    assign chk_ok   = (rf_rdata == chk_val);
    assign chk_last = (chk_k == FW'(NUM_CHECKS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; halt is tested before timeout so a same-cycle halt wins.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (load_end) state_nxt = RUN;
            RUN: begin
                if (halt)     state_nxt = CHECK;
                else if (tmo) state_nxt = DONE;
            end
            CHECK:   if (!chk_ok || chk_last) state_nxt = DONE;
            DONE:    if (start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        prog_ready = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        core_reset = 1'b1;
        busy       = 1'b0;
        done       = 1'b0;
        rf_raddr   = '0;
        case (state)
            LOAD: begin
                prog_ready = 1'b1;
                imem_we    = prog_valid;
                imem_addr  = waddr;
                imem_wdata = prog_data;
                busy       = 1'b1;
            end
            RUN: begin
                core_reset = 1'b0;
                busy       = 1'b1;
            end
            CHECK: begin
                core_reset = 1'b0;
                busy       = 1'b1;
                rf_raddr   = chk_idx;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            waddr       <= '0;
            exp_idx_q   <= '0;
            exp_val_q   <= '0;
            pc_prev     <= '0;
            chk_k       <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            overflow    <= 1'b0;
            fail_idx    <= '0;
            cycle_count <= '0;
        end else begin
            pc_prev <= pc;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        exp_idx_q   <= exp_idx;
                        exp_val_q   <= exp_val;
                        waddr       <= '0;
                        chk_k       <= '0;
                        pass        <= 1'b0;
                        timeout     <= 1'b0;
                        overflow    <= 1'b0;
                        fail_idx    <= '0;
                        cycle_count <= '0;
                    end
                end
                LOAD: begin
                    if (beat) begin
                        // Saturate at the top word rather than wrap over word 0.
                        if (!addr_full) waddr <= waddr + AW'(1);
                        if (addr_full && !prog_last) overflow <= 1'b1;
                        if (load_end) cycle_count <= 32'd1;
                    end
                end
                RUN: begin
                    if (halt)      chk_k   <= '0;
                    else if (tmo)  timeout <= 1'b1;
                    else           cycle_count <= cycle_count + 32'd1;
                end
                CHECK: begin
                    if (!chk_ok) begin
                        fail_idx <= chk_k;
                    end else if (chk_last) begin
                        pass     <= 1'b1;
                        fail_idx <= FW'(NUM_CHECKS);
                    end else begin
                        chk_k <= chk_k + FW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_test_ctrl.sv
module tb_core_test_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default depth, short timeout for the looping program.
    logic        reset, start, prog_valid, prog_last, prog_ready;
    logic [31:0] prog_data, imem_wdata, pc, rf_rdata, cycle_count;
    logic        imem_we, core_reset, busy, done, pass, timeout, overflow;
    logic [5:0]  imem_addr;
    logic [9:0]  exp_idx;
    logic [63:0] exp_val;
    logic [4:0]  rf_raddr;
    logic [1:0]  fail_idx;

    core_test_ctrl #(.XLEN(32), .IMEM_DEPTH(64), .NUM_CHECKS(2), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .start(start),
        .prog_valid(prog_valid), .prog_ready(prog_ready), .prog_data(prog_data), .prog_last(prog_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_reset(core_reset), .pc(pc), .exp_idx(exp_idx), .exp_val(exp_val),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .overflow(overflow), .fail_idx(fail_idx), .cycle_count(cycle_count)
    );

    // Small instance for the overflow scenario: 4-word memory, core parked at PC 0.
    logic        o_start, o_prog_valid, o_prog_last, o_prog_ready;
    logic [31:0] o_prog_data, o_imem_wdata, o_pc, o_rf_rdata, o_cycle_count;
    logic        o_imem_we, o_core_reset, o_busy, o_done, o_pass, o_timeout, o_overflow;
    logic [1:0]  o_imem_addr;
    logic [9:0]  o_exp_idx;
    logic [63:0] o_exp_val;
    logic [4:0]  o_rf_raddr;
    logic [1:0]  o_fail_idx;

    assign o_rf_rdata = {27'd0, o_rf_raddr};

    core_test_ctrl #(.XLEN(32), .IMEM_DEPTH(4), .NUM_CHECKS(2), .TIMEOUT_CYCLES(50)) ovf (
        .clk(clk), .reset(reset), .start(o_start),
        .prog_valid(o_prog_valid), .prog_ready(o_prog_ready), .prog_data(o_prog_data), .prog_last(o_prog_last),
        .imem_we(o_imem_we), .imem_addr(o_imem_addr), .imem_wdata(o_imem_wdata),
        .core_reset(o_core_reset), .pc(o_pc), .exp_idx(o_exp_idx), .exp_val(o_exp_val),
        .rf_raddr(o_rf_raddr), .rf_rdata(o_rf_rdata), .busy(o_busy), .done(o_done), .pass(o_pass),
        .timeout(o_timeout), .overflow(o_overflow), .fail_idx(o_fail_idx), .cycle_count(o_cycle_count)
    );

    // Minimal RV32 core: ADDI, ADD, BEQ/BNE, JAL; one instruction per cycle.
    logic [31:0] imem [64];
    logic [31:0] regs [32];
    logic [31:0] ins, rs1v, rs2v, nxt_pc, wr_val;
    logic        wr_en;

    assign rf_rdata = regs[rf_raddr];

    always_comb begin
        ins    = imem[pc[7:2]];
        rs1v   = regs[ins[19:15]];
        rs2v   = regs[ins[24:20]];
        nxt_pc = pc + 32'd4;
        wr_en  = 1'b0;
        wr_val = '0;
        case (ins[6:0])
            7'h13: begin wr_en = 1'b1; wr_val = rs1v + {{20{ins[31]}}, ins[31:20]}; end
            7'h33: begin wr_en = 1'b1; wr_val = rs1v + rs2v; end
            7'h63: if ((ins[14:12] == 3'b001) ? (rs1v != rs2v) : (rs1v == rs2v))
                       nxt_pc = pc + {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            7'h6f: nxt_pc = pc + {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
        if (core_reset) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else begin
            pc <= nxt_pc;
            if (wr_en && ins[11:7] != 5'd0) regs[ins[11:7]] <= wr_val;
        end
    end

    // Scoreboards
    typedef struct packed { logic [5:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic pass; logic timeout; logic [1:0] fail_idx; logic [31:0] cycles; } res_t;
    wr_t         wr_q [$];
    res_t        res_q [$];
    logic [31:0] prog [$];

    int errors = 0;
    int checks = 0;

    task automatic set_sum_prog();
        prog = '{32'h00500093, 32'h00000113, 32'h00110133, 32'hfff08093,
                 32'hfe009ce3, 32'h00000013, 32'h0000006f};
    endtask

    task automatic start_seq(input logic [9:0] idx, input logic [63:0] val);
        @(posedge clk); #1;
        exp_idx = idx; exp_val = val; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, prog_ready, core_reset, done, pass, timeout, overflow} !== 7'b1110000 ||
            cycle_count !== 32'd0 || fail_idx !== 2'd0)
            begin errors++; $display("FAIL load_entry: busy/rdy/crst/done/pass/tmo/ovf=%b cc=%0d fidx=%0d want 1110000 0 0",
                {busy, prog_ready, core_reset, done, pass, timeout, overflow}, cycle_count, fail_idx); end
    endtask

    task automatic load_prog(input bit toggle);
        int i; int cyc; logic [5:0] a; bit ph; wr_t w;
        i = 0; cyc = 0; a = '0; ph = 1'b1;
        wr_q.delete();
        while (i < prog.size() && cyc < 100) begin
            prog_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            prog_data = prog_valid ? prog[i] : 32'hbad0_0000;
            prog_last = (i == prog.size() - 1);
            if (prog_valid) wr_q.push_back({a, prog[i]});
            @(negedge clk);
            checks++;
            if (imem_we !== prog_valid || prog_ready !== 1'b1)
                begin errors++; $display("FAIL load_we: we=%b rdy=%b want we=%b rdy=1", imem_we, prog_ready, prog_valid); end
            if (imem_we && wr_q.size() > 0) begin
                w = wr_q.pop_front();
                checks++;
                if (imem_addr !== w.addr || imem_wdata !== w.data)
                    begin errors++; $display("FAIL imem_write: addr=%0d data=%h want addr=%0d data=%h", imem_addr, imem_wdata, w.addr, w.data); end
            end
            if (prog_valid && prog_ready) begin i++; a++; end
            cyc++;
            @(posedge clk); #1;
        end
        prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
        checks++;
        if (i != prog.size() || wr_q.size() != 0)
            begin errors++; $display("FAIL load_count: beats=%0d pending=%0d want %0d 0", i, wr_q.size(), prog.size()); end
        @(negedge clk);
        checks++;
        if ({busy, core_reset, imem_we, prog_ready} !== 4'b1000 || cycle_count !== 32'd1)
            begin errors++; $display("FAIL run_entry: busy/crst/we/rdy=%b cc=%0d want 1000 1", {busy, core_reset, imem_we, prog_ready}, cycle_count); end
    endtask

    task automatic wait_done(output bit ok, output int chk_cyc);
        ok = 1'b0; chk_cyc = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (rf_raddr != 5'd0) chk_cyc++;
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({core_reset, prog_ready, imem_we, busy, done, pass, timeout, overflow} !== 8'b1000_0000)
            begin errors++; $display("FAIL reset_flags: got %b want 10000000", {core_reset, prog_ready, imem_we, busy, done, pass, timeout, overflow}); end
        checks++;
        if (imem_addr !== 6'd0 || fail_idx !== 2'd0 || cycle_count !== 32'd0 || rf_raddr !== 5'd0)
            begin errors++; $display("FAIL reset_values: addr=%0d fidx=%0d cc=%0d raddr=%0d want all 0", imem_addr, fail_idx, cycle_count, rf_raddr); end
        checks++;
        if (o_core_reset !== 1'b1 || o_busy !== 1'b0 || o_overflow !== 1'b0)
            begin errors++; $display("FAIL reset_ovf_inst: crst=%b busy=%b ovf=%b want 1 0 0", o_core_reset, o_busy, o_overflow); end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL idle_hold: busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic check_result(input string name, input int chk_cyc, input int want_chk);
        res_t r;
        r = res_q.pop_front();
        checks++;
        if ({done, pass, timeout, overflow} !== {1'b1, r.pass, r.timeout, 1'b0} || fail_idx !== r.fail_idx)
            begin errors++; $display("FAIL %s_flags: done/pass/tmo/ovf=%b fidx=%0d want %b %0d", name,
                {done, pass, timeout, overflow}, fail_idx, {1'b1, r.pass, r.timeout, 1'b0}, r.fail_idx); end
        checks++;
        if (cycle_count !== r.cycles)
            begin errors++; $display("FAIL %s_cycles: cc=%0d want %0d", name, cycle_count, r.cycles); end
        checks++;
        if (chk_cyc != want_chk)
            begin errors++; $display("FAIL %s_check_len: %0d want %0d", name, chk_cyc, want_chk); end
        checks++;
        if (busy !== 1'b0 || core_reset !== 1'b1)
            begin errors++; $display("FAIL %s_done_outs: busy=%b crst=%b want 0 1", name, busy, core_reset); end
    endtask

    task automatic test_sum_pass();
        bit ok; int cc;
        set_sum_prog();
        start_seq({5'd2, 5'd1}, {32'd15, 32'd0});
        res_q.push_back({1'b1, 1'b0, 2'd2, 32'd20});
        load_prog(1'b0);
        wait_done(ok, cc);
        checks++;
        if (!ok) begin errors++; $display("FAIL sum_pass_done: done=%b want 1", done); end
        check_result("sum_pass", cc, 2);
    endtask

    task automatic test_sum_fail();
        bit ok; int cc;
        set_sum_prog();
        start_seq({5'd2, 5'd1}, {32'd14, 32'd0});
        res_q.push_back({1'b0, 1'b0, 2'd1, 32'd20});
        load_prog(1'b0);
        // start and new expectations during RUN must be ignored.
        @(posedge clk); #1;
        start = 1'b1; exp_val = {32'd15, 32'd0};
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(ok, cc);
        checks++;
        if (!ok) begin errors++; $display("FAIL sum_fail_done: done=%b want 1", done); end
        check_result("sum_fail", cc, 2);
    endtask

    task automatic test_timeout();
        bit ok; int cc;
        prog = '{32'h00500093, 32'h00000113, 32'h00110133, 32'hfff08093,
                 32'hfe009ce3, 32'h0040006f, 32'hffdff06f};
        start_seq({5'd2, 5'd1}, {32'd15, 32'd0});
        res_q.push_back({1'b0, 1'b1, 2'd0, 32'd100});
        load_prog(1'b0);
        wait_done(ok, cc);
        checks++;
        if (!ok) begin errors++; $display("FAIL timeout_done: done=%b want 1", done); end
        check_result("timeout", cc, 0);
    endtask

    task automatic test_overflow();
        int i; int cyc; int writes; bit ok;
        @(posedge clk); #1; o_start = 1'b1;
        @(posedge clk); #1; o_start = 1'b0;
        i = 0; cyc = 0; writes = 0;
        while (cyc < 20) begin
            o_prog_valid = 1'b1;
            o_prog_data  = 32'hA000_0000 + 32'(i);
            o_prog_last  = (i == 5);
            @(negedge clk);
            if (!o_prog_ready) break;
            if (o_imem_we) begin
                writes++;
                checks++;
                if (o_imem_addr !== 2'(i) || o_imem_wdata !== 32'hA000_0000 + 32'(i))
                    begin errors++; $display("FAIL ovf_write: addr=%0d data=%h want %0d %h", o_imem_addr, o_imem_wdata, i, 32'hA000_0000 + 32'(i)); end
            end
            i++; cyc++;
            @(posedge clk); #1;
        end
        o_prog_valid = 1'b0; o_prog_last = 1'b0;
        checks++;
        if (i != 4 || writes != 4)
            begin errors++; $display("FAIL ovf_beats: beats=%0d writes=%0d want 4 4", i, writes); end
        checks++;
        if ({o_overflow, o_busy, o_core_reset, o_imem_we} !== 4'b1100 || o_cycle_count !== 32'd1)
            begin errors++; $display("FAIL ovf_run_entry: ovf/busy/crst/we=%b cc=%0d want 1100 1", {o_overflow, o_busy, o_core_reset, o_imem_we}, o_cycle_count); end
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (o_done) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok || {o_pass, o_timeout, o_overflow} !== 3'b101 || o_fail_idx !== 2'd2 || o_cycle_count !== 32'd2)
            begin errors++; $display("FAIL ovf_result: done=%b pass/tmo/ovf=%b fidx=%0d cc=%0d want 1 101 2 2",
                o_done, {o_pass, o_timeout, o_overflow}, o_fail_idx, o_cycle_count); end
    endtask

    task automatic test_reset_mid_run();
        bit ok; int cc;
        set_sum_prog();
        start_seq({5'd2, 5'd1}, {32'd15, 32'd0});
        res_q.push_back({1'b1, 1'b0, 2'd2, 32'd20});
        load_prog(1'b0);
        @(posedge clk); #1;
        start = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        res_q.delete();
        @(negedge clk);
        checks++;
        if ({busy, core_reset, done, pass} !== 4'b0100 || cycle_count !== 32'd0 || rf_raddr !== 5'd0)
            begin errors++; $display("FAIL mid_reset: busy/crst/done/pass=%b cc=%0d want 0100 0", {busy, core_reset, done, pass}, cycle_count); end
        start_seq({5'd2, 5'd1}, {32'd15, 32'd0});
        res_q.push_back({1'b1, 1'b0, 2'd2, 32'd20});
        load_prog(1'b0);
        wait_done(ok, cc);
        checks++;
        if (!ok) begin errors++; $display("FAIL rerun_done: done=%b want 1", done); end
        check_result("rerun", cc, 2);
    endtask

    task automatic test_toggle_valid();
        bit ok; int cc;
        set_sum_prog();
        start_seq({5'd2, 5'd1}, {32'd15, 32'd0});
        res_q.push_back({1'b1, 1'b0, 2'd2, 32'd20});
        load_prog(1'b1);
        wait_done(ok, cc);
        checks++;
        if (!ok) begin errors++; $display("FAIL toggle_done: done=%b want 1", done); end
        check_result("toggle", cc, 2);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_valid = 1'b0; prog_last = 1'b0; prog_data = '0;
        exp_idx = '0; exp_val = '0;
        o_start = 1'b0; o_prog_valid = 1'b0; o_prog_last = 1'b0; o_prog_data = '0;
        o_pc = '0; o_exp_idx = '0; o_exp_val = '0;
        test_reset();
        test_sum_pass();
        test_sum_fail();
        test_timeout();
        test_overflow();
        test_reset_mid_run();
        test_toggle_valid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
